// File: rtl/npu_pkg.sv
// Shared NPU definitions: weight-feeder state encoding, byte type and the
// default kernel geometry common to the feeder and the weight register.
package npu_pkg;

  localparam int unsigned K_H_DEF = 3;
  localparam int unsigned K_W_DEF = 3;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    LAST,
    RUN,
    DONE
  } w_feeder_state_t;

endpackage

// File: rtl/w_feeder_if.sv
// Weight-feeder bus: weight-SRAM read port plus the weight-register
// clear/load/shift/data port. The feeder is the master on both.
interface w_feeder_if
  import npu_pkg::*;
#(
  parameter int unsigned K_H    = K_H_DEF,
  parameter int unsigned ADDR_W = 10
);

  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [8*K_H-1:0]  mem_rdata;
  logic              w_clear;
  logic              w_load_en;
  logic              w_shift;
  byte_t             w_data [K_H];

  modport master (
    output mem_re, mem_addr, w_clear, w_load_en, w_shift, w_data,
    input  mem_rdata
  );

  modport slave (
    input  mem_re, mem_addr, w_clear, w_load_en, w_shift, w_data,
    output mem_rdata
  );

endinterface

// File: rtl/w_feeder.sv
// Weight feeder: clears a PE weight register, loads K_W kernel columns from
// weight SRAM, then issues rotate pulses on demand until n_shift are done.
module w_feeder
  import npu_pkg::*;
#(
  parameter int unsigned K_H    = K_H_DEF,
  parameter int unsigned K_W    = K_W_DEF,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  n_shift,
  input  logic              adv,
  output logic              busy,
  output logic              w_ready,
  output logic              done,
  w_feeder_if.master        wif
);

  localparam int unsigned FI_W = (K_W > 1) ? $clog2(K_W) : 1;

  w_feeder_state_t   state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  cnt;
  logic [FI_W-1:0]   fidx;
  logic              load_q;
  logic [ADDR_W-1:0] addr_off;
  logic              mem_re_i;
  logic              w_shift_i;
  logic              last_fetch;

  assign last_fetch = (fidx == FI_W'(K_W - 1));

  // Columns 1..K_W-1 first, column 0 last, so column 0 lands at the register head.
  always_comb begin
    addr_off = '0;
    if (!last_fetch) addr_off = ADDR_W'(fidx) + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      base_q <= '0;
      n_q    <= '0;
      cnt    <= '0;
      fidx   <= '0;
      load_q <= 1'b0;
    end else begin
      state  <= state_nx;
      load_q <= mem_re_i;
      if (state == IDLE && start) begin
        base_q <= base_addr;
        n_q    <= n_shift;
      end
      if (state == CLEAR) begin
        fidx <= '0;
        cnt  <= '0;
      end
      if (state == FETCH) fidx <= fidx + FI_W'(1);
      if (w_shift_i) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx      = state;
    busy          = (state != IDLE);
    w_ready       = (state == RUN);
    done          = (state == DONE);
    mem_re_i      = (state == FETCH);
    w_shift_i     = (state == RUN) && adv;
    wif.w_clear   = (state == CLEAR);
    wif.w_load_en = load_q;
    wif.mem_addr  = '0;
    if (mem_re_i) wif.mem_addr = base_q + addr_off;
    unique case (state)
      IDLE:    if (start) state_nx = CLEAR;
      CLEAR:   state_nx = FETCH;
      FETCH:   if (last_fetch) state_nx = LAST;
      LAST:    state_nx = (n_q == '0) ? DONE : RUN;
      RUN:     if (adv && (cnt == n_q - CNT_W'(1))) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign wif.mem_re  = mem_re_i;
  assign wif.w_shift = w_shift_i;

  always_comb begin
    for (int unsigned i = 0; i < K_H; i++) begin
      wif.w_data[i] = wif.mem_rdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_w_feeder.sv
// Directed bench for w_feeder with a weight-SRAM model, a circular
// weight-register model and address/register-head scoreboards.
module tb_w_feeder;
  import npu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [15:0] n_shift;
  logic        adv;
  logic        busy, w_ready, done;

  w_feeder_if #(.K_H(3), .ADDR_W(10)) wif ();

  w_feeder #(.K_H(3), .K_W(3), .ADDR_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .n_shift(n_shift), .adv(adv), .busy(busy), .w_ready(w_ready),
    .done(done), .wif(wif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int shift_cnt = 0;
  int load_cnt  = 0;
  logic pend = 1'b0;

  logic [9:0]  addr_q [$];
  logic [23:0] reg_q  [$];
  logic [23:0] mem  [1024];
  logic [23:0] wreg [3];
  logic [23:0] wd;

  assign wd = {wif.w_data[2], wif.w_data[1], wif.w_data[0]};

  always @(posedge clk) if (wif.mem_re) wif.mem_rdata <= mem[wif.mem_addr];

  // Circular register: loads enter at the head; a rotate brings the tail to the head.
  always @(posedge clk) begin
    if (wif.w_clear) begin
      for (int i = 0; i < 3; i++) wreg[i] <= '0;
    end else if (wif.w_load_en) begin
      wreg[0] <= wd;
      wreg[1] <= wreg[0];
      wreg[2] <= wreg[1];
    end else if (wif.w_shift) begin
      wreg[0] <= wreg[2];
      wreg[1] <= wreg[0];
      wreg[2] <= wreg[1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wif.w_load_en) load_cnt++;
    if (!rst) begin
      chk("excl", 32'($countones({wif.w_clear, wif.w_load_en, wif.w_shift}) <= 1), 32'd1);
      chk("shift_wo_adv", 32'(wif.w_shift && !adv), 32'd0);
      if (pend) begin
        pend = 1'b0;
        if (reg_q.size() == 0) chk("reg_q_size", 32'(reg_q.size()), 32'd1);
        else chk("head", 32'(wreg[0]), 32'(reg_q.pop_front()));
      end
      if (wif.w_shift) begin
        shift_cnt++;
        pend = 1'b1;
      end
      if (wif.mem_re) begin
        if (addr_q.size() == 0) chk("addr_q_size", 32'(addr_q.size()), 32'd1);
        else chk("mem_addr", 32'(wif.mem_addr), 32'(addr_q.pop_front()));
      end
    end else begin
      pend = 1'b0;
    end
  end

  function automatic logic [23:0] col_word(input logic [9:0] b, input int unsigned c);
    logic [23:0] w;
    for (int unsigned r = 0; r < 3; r++) w[8*r +: 8] = 8'(32'(b) * 7 + c * 37 + r * 3 + 1);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prep(input logic [9:0] b, input int unsigned n, output logic [23:0] c0);
    logic [9:0] a;
    for (int unsigned i = 0; i < 3; i++) begin
      a = b + 10'(i);
      mem[a] = col_word(b, i);
    end
    addr_q.push_back(b + 10'd1);
    addr_q.push_back(b + 10'd2);
    addr_q.push_back(b);
    for (int unsigned k = 1; k <= n; k++) reg_q.push_back(col_word(b, k % 3));
    c0 = col_word(b, 0);
  endtask

  task automatic kick(input logic [9:0] b, input int unsigned n);
    base_addr = b;
    n_shift   = 16'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Full run with adv held high; checks the fixed cycle timeline after start.
  task automatic run_full(input logic [9:0] b, input int unsigned n);
    logic [23:0] c0;
    int s0;
    prep(b, n, c0);
    s0  = shift_cnt;
    adv = 1'b1;
    kick(b, n);
    chk("clear_c1", 32'(wif.w_clear), 32'd1);
    chk("busy_c1", 32'(busy), 32'd1);
    for (int cy = 2; cy <= 5; cy++) begin
      tick();
      chk("mem_re_tl", 32'(wif.mem_re), 32'(cy <= 4));
      chk("load_tl", 32'(wif.w_load_en), 32'(cy >= 3));
    end
    tick();
    chk("head_c6", 32'(wreg[0]), 32'(c0));
    chk("w_ready_c6", 32'(w_ready), 32'(n != 0));
    repeat (n) tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("no_shift_done", 32'(wif.w_shift), 32'd0);
    tick();
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    chk("shift_count", 32'(shift_cnt - s0), 32'(n));
    chk("reg_q_empty", 32'(reg_q.size()), 32'd0);
    chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
    adv = 1'b0;
  endtask

  initial begin
    logic [23:0] c0;
    int s0, l0, done_k;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    rst = 1'b1; start = 1'b0; adv = 1'b0; base_addr = '0; n_shift = '0;
    tick(); tick();
    chk("rst_outs", 32'({busy, w_ready, done, wif.mem_re, wif.w_clear,
                         wif.w_load_en, wif.w_shift}), 32'd0);
    chk("rst_addr", 32'(wif.mem_addr), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Load and six back-to-back rotates
    run_full(10'h010, 6);

    // adv toggling with stray start pulses while running
    prep(10'h010, 4, c0);
    s0 = shift_cnt;
    kick(10'h010, 4);
    repeat (5) tick();
    chk("head_b", 32'(wreg[0]), 32'(c0));
    done_k = -1;
    for (int k = 0; k < 25; k++) begin
      adv   = (k % 2 == 0);
      start = (k == 1 || k == 3);
      if (done) begin
        done_k = k;
        break;
      end
      tick();
    end
    start = 1'b0; adv = 1'b0;
    chk("done_cycle_b", 32'(done_k), 32'd7);
    tick();
    chk("busy_b", 32'(busy), 32'd0);
    chk("shift_count_b", 32'(shift_cnt - s0), 32'd4);
    chk("reg_q_b", 32'(reg_q.size()), 32'd0);

    // Zero rotates
    run_full(10'h040, 0);

    // Reset in the middle of the fetch
    prep(10'h020, 0, c0);
    kick(10'h020, 3);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", 32'({busy, w_ready, done, wif.mem_re, wif.w_clear,
                             wif.w_load_en, wif.w_shift}), 32'd0);
    chk("rst_mid_addr", 32'(wif.mem_addr), 32'd0);
    l0 = load_cnt;
    repeat (3) tick();
    rst = 1'b0;
    addr_q.delete();
    reg_q.delete();
    repeat (3) tick();
    chk("no_load_after_rst", 32'(load_cnt - l0), 32'd0);
    chk("busy_after_rst", 32'(busy), 32'd0);
    run_full(10'h020, 3);

    // Address wrap at the top of the weight memory
    run_full(10'h3ff, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
